// File: rtl/div_array_share_ctrl.sv
// Two-requester front end for one combinational 16/8 restoring array divider.
// Operands are held on the array for SETTLE_CYCLES before the result is captured.
module div_array_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NREQ          = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_n,
    input  logic [8*NREQ-1:0]    req_d,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [7:0]           rsp_q,
    output logic [7:0]           rsp_r,
    output logic                 rsp_dz,
    output logic                 rsp_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            owner_q, owner_d;
    logic [15:0]     n_q, n_d;
    logic [7:0]      d_q, d_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]      q_q, q_d, r_q, r_d;
    logic            dz_q, dz_d, ovf_q, ovf_d;

    logic            gnt;
    logic [7:0]      arr_q, arr_r, rem;
    logic [8:0]      sh;
    logic [9:0]      diff;
    logic            d_zero;

    // Restoring array: each row shifts in one dividend bit and keeps the
    // difference only when the subtraction does not borrow.
    always_comb begin
        rem   = n_q[15:8];
        arr_q = '0;
        sh    = '0;
        diff  = '0;
        for (int i = 7; i >= 0; i--) begin
            sh       = {rem, n_q[i]};
            diff     = {1'b0, sh} - {2'b00, d_q};
            arr_q[i] = ~diff[9];
            rem      = diff[9] ? sh[7:0] : diff[7:0];
        end
        arr_r = rem;
    end

    // Pointer only matters when both requesters are valid.
    assign gnt    = (req_valid == {NREQ{1'b1}}) ? ptr_q : req_valid[1];
    assign d_zero = (d_q == 8'd0);

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == StIdle && |req_valid) begin
            req_ready = NREQ'(1) << gnt;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        n_d         = n_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        q_d         = q_q;
        r_d         = r_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    owner_d = gnt;
                    n_d     = gnt ? req_n[31:16] : req_n[15:0];
                    d_d     = gnt ? req_d[15:8] : req_d[7:0];
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    q_d         = d_zero ? 8'hFF : arr_q;
                    r_d         = d_zero ? n_q[7:0] : arr_r;
                    dz_d        = d_zero;
                    ovf_d       = !d_zero && (n_q[15:8] >= d_q);
                    rsp_valid_d = NREQ'(1) << owner_q;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = ~owner_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            n_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            n_q         <= n_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = q_q;
    assign rsp_r     = r_q;
    assign rsp_dz    = dz_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_div_array_share_ctrl.sv
// Scoreboard bench: three instances (settle 2, 1, 5) share stimulus; the settle-2
// instance is fully checked, the others are checked for latency and reset.
module tb_div_array_share_ctrl;

    typedef struct packed {
        logic       owner;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_n;
    logic [15:0] req_d;
    logic [1:0]  rsp_ready;

    logic [1:0]  req_ready_a [3];
    logic [1:0]  rsp_valid_a [3];
    logic [7:0]  q_a [3];
    logic [7:0]  r_a [3];
    logic        dz_a [3];
    logic        ovf_a [3];
    logic        busy_a [3];

    int          settle [3] = '{2, 1, 5};
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        exp_q [$];

    int          grant_cyc [3];
    bit          have_grant [3];
    bit          prev_valid [3];
    int          rise_cnt [3] = '{0, 0, 0};

    div_array_share_ctrl #(.SETTLE_CYCLES(2), .NREQ(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[0]),
        .req_n(req_n), .req_d(req_d), .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready),
        .rsp_q(q_a[0]), .rsp_r(r_a[0]), .rsp_dz(dz_a[0]), .rsp_ovf(ovf_a[0]),
        .busy(busy_a[0])
    );

    div_array_share_ctrl #(.SETTLE_CYCLES(1), .NREQ(2)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[1]),
        .req_n(req_n), .req_d(req_d), .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready),
        .rsp_q(q_a[1]), .rsp_r(r_a[1]), .rsp_dz(dz_a[1]), .rsp_ovf(ovf_a[1]),
        .busy(busy_a[1])
    );

    div_array_share_ctrl #(.SETTLE_CYCLES(5), .NREQ(2)) u_dut5 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[2]),
        .req_n(req_n), .req_d(req_d), .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready),
        .rsp_q(q_a[2]), .rsp_r(r_a[2]), .rsp_dz(dz_a[2]), .rsp_ovf(ovf_a[2]),
        .busy(busy_a[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input logic o, input logic [7:0] q, input logic [7:0] r,
                                 input logic dz, input logic ovf);
        exp_t e;
        e.owner = o;
        e.q     = q;
        e.r     = r;
        e.dz    = dz;
        e.ovf   = ovf;
        exp_q.push_back(e);
    endfunction

    // Monitor: latency per instance, scoreboard pops on settle-2 handshakes.
    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            have_grant[k] = 0;
            prev_valid[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    have_grant[k] = 0;
                    prev_valid[k] = 0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if ((req_valid & req_ready_a[k]) != 2'b00) begin
                        grant_cyc[k]  = cyc;
                        have_grant[k] = 1;
                    end
                    if (rsp_valid_a[k] != 2'b00 && !prev_valid[k]) begin
                        rise_cnt[k]++;
                        if (have_grant[k])
                            check($sformatf("latency_s%0d", settle[k]),
                                  cyc - grant_cyc[k], settle[k] + 1);
                        have_grant[k] = 0;
                    end
                    prev_valid[k] = (rsp_valid_a[k] != 2'b00);
                end
                if ((rsp_valid_a[0] & rsp_ready) != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", int'(rsp_valid_a[0]), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_owner", int'(rsp_valid_a[0]), e.owner ? 2 : 1);
                        check("rsp_q", int'(q_a[0]), int'(e.q));
                        check("rsp_r", int'(r_a[0]), int'(e.r));
                        check("rsp_dz", int'(dz_a[0]), int'(e.dz));
                        check("rsp_ovf", int'(ovf_a[0]), int'(e.ovf));
                    end
                end
            end
        end
    end

    task automatic check_zero(input int k, input string tag);
        check({tag, "_req_ready"}, int'(req_ready_a[k]), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid_a[k]), 0);
        check({tag, "_q"}, int'(q_a[k]), 0);
        check({tag, "_r"}, int'(r_a[k]), 0);
        check({tag, "_dz"}, int'(dz_a[k]), 0);
        check({tag, "_ovf"}, int'(ovf_a[k]), 0);
        check({tag, "_busy"}, int'(busy_a[k]), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input int idx, input logic [15:0] n, input logic [7:0] d);
        bit ok = 0;
        req_n[idx*16 +: 16] = n;
        req_d[idx*8 +: 8]   = d;
        req_valid[idx]      = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (req_ready_a[0][idx]) ok = 1;
        end
        check("grant_seen", int'(ok), 1);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (!busy_a[0] && exp_q.size() == 0) ok = 1;
        end
        check("drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int base1, base5;
        bit ok;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_n     = '0;
        req_d     = '0;
        rsp_ready = 2'b00;

        // Reset state on all instances
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset_s%0d", settle[k]));
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester 0: 100/7
        rsp_ready = 2'b11;
        push(1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
        issue(0, 16'd100, 8'd7);
        wait_idle();

        // Both valid: grants alternate 0,1,0,1 every 4 cycles
        do_reset();
        push(1'b0, 8'd20, 8'd0, 1'b0, 1'b0);
        push(1'b1, 8'd10, 8'd0, 1'b0, 1'b0);
        push(1'b0, 8'd20, 8'd0, 1'b0, 1'b0);
        push(1'b1, 8'd10, 8'd0, 1'b0, 1'b0);
        req_n     = {16'd50, 16'd200};
        req_d     = {8'd5, 8'd10};
        req_valid = 2'b11;
        last      = 0;
        for (int g = 0; g < 4; g++) begin
            ok = 0;
            for (int c = 0; c < 40 && !ok; c++) begin
                @(negedge clk);
                if ((req_valid & req_ready_a[0]) != 2'b00) ok = 1;
            end
            check("alt_grant_seen", int'(ok), 1);
            check("alt_owner", int'(req_ready_a[0]), (g % 2 == 1) ? 2 : 1);
            if (g > 0) check("alt_spacing", cyc - last, 4);
            last = cyc;
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_idle();

        // Divide by zero on requester 1
        push(1'b1, 8'hFF, 8'h34, 1'b1, 1'b0);
        issue(1, 16'h1234, 8'd0);
        wait_idle();

        // Quotient overflow: array result passed through with ovf set
        push(1'b0, 8'hFF, 8'h08, 1'b0, 1'b1);
        issue(0, 16'h0900, 8'd8);
        wait_idle();

        // Back-pressure: 1000/33 held, then pending req1 300/20
        do_reset();
        rsp_ready = 2'b00;
        push(1'b0, 8'd30, 8'd10, 1'b0, 1'b0);
        push(1'b1, 8'd15, 8'd0, 1'b0, 1'b0);
        issue(0, 16'd1000, 8'd33);
        req_n[31:16]  = 16'd300;
        req_d[15:8]   = 8'd20;
        req_valid[1]  = 1'b1;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid_a[0][0]) ok = 1;
        end
        check("bp_valid_seen", int'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", int'(rsp_valid_a[0]), 1);
            check("bp_q", int'(q_a[0]), 30);
            check("bp_r", int'(r_a[0]), 10);
            check("bp_flags", int'({dz_a[0], ovf_a[0]}), 0);
            check("bp_req_ready", int'(req_ready_a[0]), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_grant", int'(req_ready_a[0]), 2);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_idle();

        // Reset during SETTLE drops the job on every instance
        do_reset();
        issue(0, 16'd500, 8'd9);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k, $sformatf("midrst_s%0d", settle[k]));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check($sformatf("no_stale_s%0d", settle[k]), int'(rsp_valid_a[k]), 0);
        end

        // Latency scales with settle window (1, 2, 5)
        base1 = rise_cnt[1];
        base5 = rise_cnt[2];
        @(posedge clk);
        #1;
        push(1'b0, 8'd25, 8'd2, 1'b0, 1'b0);
        issue(0, 16'd77, 8'd3);
        repeat (12) @(posedge clk);
        #1;
        check("rsp_seen_s1", rise_cnt[1] - base1, 1);
        check("rsp_seen_s5", rise_cnt[2] - base5, 1);
        wait_idle();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_array_share_ctrl.md
Name: div_array_share_ctrl

Overview:
- Time-shares one combinational 16/8 restoring array divider datapath (one exact/approximate subtractor-cell array) between two requesters.
- Round-robin arbitration; valid/ready request and response channels.
- Registers operands and holds them stable for a programmable settle window, because the array's borrow ripple is too long for one cycle.
- Registers quotient/remainder and flags for divide-by-zero and quotient overflow.

Parameters:
- SETTLE_CYCLES, 2, cycles operands are held on the array before capture; legal range 1..15.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accepted this cycle
- req_n  in  32  dividends, requester i on bits [16i+15:16i]
- req_d  in  16  divisors, requester i on bits [8i+7:8i]
- rsp_valid  out  2  per-requester result valid
- rsp_ready  in  2  per-requester result consumed
- rsp_q  out  8  quotient, shared bus, owned by the requester with rsp_valid set
- rsp_r  out  8  remainder, shared bus
- rsp_dz  out  1  divisor was zero
- rsp_ovf  out  1  n[15:8] >= d, so the quotient does not fit in 8 bits
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, takes priority over all activity):
  - FSM goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_q=0, rsp_r=0, rsp_dz=0, rsp_ovf=0, busy=0.
  - Round-robin pointer set to 0; operand registers cleared.
  - Reset mid-operation drops the in-flight job with no response.
- FSM states:
  - IDLE: if any req_valid, grant one requester. req_ready of the grantee is 1 combinationally in the same cycle; the other requester's req_ready is 0. Latch n, d and the owner id; go to SETTLE with the counter loaded to SETTLE_CYCLES-1.
  - SETTLE: the operand registers drive the array unchanged. Decrement the counter; at 0, capture the array's q/r into the output registers, compute flags, go to RESP.
  - RESP: rsp_valid[owner]=1. When rsp_ready[owner]=1, clear rsp_valid, go to IDLE, and toggle the pointer away from the owner.
- Arbitration:
  - If only one requester is valid, it is granted regardless of the pointer.
  - If both are valid, the pointer picks the grantee; the pointer advances only on response completion.
  - There is no back-to-back overlap: a new grant can occur at the earliest in the cycle after the RESP handshake.
- Latency:
  - Accept at edge t; rsp_valid rises after edge t+SETTLE_CYCLES.
  - With the default, the result is visible 2 cycles after acceptance; throughput is 1 job per SETTLE_CYCLES+2 cycles when the consumer is always ready.
- Arithmetic and flags:
  - The array computes q/r from the registered n and d; q and r are 8 bits each.
  - dz = (d==0). When dz=1, force q=8'hFF and r=n[7:0], ignoring the array.
  - ovf = (d!=0) && (n[15:8] >= d). When ovf=1, q and r are passed through from the array unchanged; the flag marks them invalid.
  - When both flags could apply, dz has precedence and ovf=0.
- Output stability:
  - rsp_q, rsp_r and the flags hold from entry into RESP until the handshake, and keep their values after it until the next capture.
  - rsp_valid never drops without rsp_ready.
- req_ready is 0 in SETTLE and RESP; requests arriving then stall until IDLE.
- Simultaneous events:
  - rsp_ready while not valid: ignored.
  - req_valid withdrawn before grant: legal, nothing latched.

Test Plan:
- Single requester 0, n=100, d=7, rsp_ready=1 → rsp_valid[0] after exactly 2 cycles (default settle). q/r match the bit-level core model (exact reference 14/2). dz=0, ovf=0.
- Both requesters valid continuously: req0 n=200,d=10; req1 n=50,d=5 → grants alternate 0,1,0,1. Each rsp_valid is asserted only on its owner's bit. Job spacing is 4 cycles.
- Divide by zero: n=16'h1234, d=0 → dz=1, ovf=0, q=8'hFF, r=8'h34.
- Overflow: n=16'h0900, d=8 → ovf=1, dz=0; rsp_valid still asserts and the handshake completes normally.
- Back-pressure: hold rsp_ready=0 for 10 cycles → rsp_valid, q, r and flags stay stable; req_ready stays 0; the pending req1 is granted the cycle after rsp_ready rises.
- Reset during SETTLE, and repeated with SETTLE_CYCLES=1 and 5 → all outputs 0 and no stale response on the next cycle; latency scales to SETTLE_CYCLES.
